// File: rtl/vp_pkg.sv
// vp_pkg -- shared definitions for the video pattern / timing generator.
//
// Purpose:
//   Pattern selector codes, the colour-bar lookup table, the FSM state type
//   and the default 1280x720 timing numbers used as parameter defaults.
//
// Contents:
//   COORD_W            width of the x/y coordinate buses and line/frame counters
//   PAT_*              pattern_sel encodings
//   DEF_*              default 720p timing (active, front porch, sync, back porch)
//   vtg_state_t        two-state run/idle FSM encoding
//   bar_colour()       colour-bar table, index 0 = leftmost bar
package vp_pkg;

  localparam int COORD_W = 12;

  localparam logic [1:0] PAT_BARS     = 2'd0;
  localparam logic [1:0] PAT_GRADIENT = 2'd1;
  localparam logic [1:0] PAT_CHECKER  = 2'd2;
  localparam logic [1:0] PAT_SOLID    = 2'd3;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 110;
  localparam int DEF_H_SYNC   = 40;
  localparam int DEF_H_BP     = 220;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 5;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 20;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtg_state_t;

  // Standard eight-bar sequence, left to right, as {R,G,B}.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vtg_counter.sv
// vtg_counter -- wrap-around counter with carry-out.
//
// Purpose:
//   Counts 0..MODULUS-1 while inc is high and wraps to 0. carry is high in
//   the cycle where an increment wraps the counter, so chaining carry into
//   the inc of a second counter gives a line/frame counter pair.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the count
//   clear  in   synchronous clear to 0 (dominates inc)
//   inc    in   advance by one this clock
//   count  out  current count value
//   carry  out  inc is high and count is at MODULUS-1
module vtg_counter #(
  parameter int WIDTH   = 12,
  parameter int MODULUS = 1650
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  assign carry = inc && (count == LAST);

  // Count register: clear wins over increment, increment wraps at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= carry ? '0 : count + ONE;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen -- raster timing and test-pattern generator.
//
// Purpose:
//   Generates a progressive raster (active, front porch, sync, back porch in
//   both dimensions) with active-high syncs and a test pattern. Every output
//   is registered and reflects the counter state of the previous clock.
//   Frames are never truncated by en; only rst_n stops a frame early.
//
// Ports:
//   clk          in   pixel clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   run request, level-sensitive
//   pattern_sel  in   0 bars, 1 gradient, 2 checkerboard, 3 solid
//   solid_rgb    in   colour for the solid pattern, {R,G,B}
//   de_out       out  active-video flag
//   h_sync_out   out  horizontal sync, active-high
//   v_sync_out   out  vertical sync, active-high
//   pixel_out    out  {R,G,B}, 0 outside active video
//   x_out/y_out  out  coordinates of the pixel on pixel_out, 0 outside active
//   frame_start  out  one-cycle pulse with the first active pixel of a frame
//   busy         out  high while a frame is being generated
module video_timing_gen #(
  parameter int H_ACTIVE = vp_pkg::DEF_H_ACTIVE,
  parameter int H_FP     = vp_pkg::DEF_H_FP,
  parameter int H_SYNC   = vp_pkg::DEF_H_SYNC,
  parameter int H_BP     = vp_pkg::DEF_H_BP,
  parameter int V_ACTIVE = vp_pkg::DEF_V_ACTIVE,
  parameter int V_FP     = vp_pkg::DEF_V_FP,
  parameter int V_SYNC   = vp_pkg::DEF_V_SYNC,
  parameter int V_BP     = vp_pkg::DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        de_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [23:0] pixel_out,
  output logic [11:0] x_out,
  output logic [11:0] y_out,
  output logic        frame_start,
  output logic        busy
);

  import vp_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] BARS_END = COORD_W'(8 * BAR_W);

  vtg_state_t state, state_next;
  logic run;
  logic latch_load;

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic h_carry, v_carry;

  logic [1:0]  pat_q;
  logic [23:0] rgb_q;

  logic [2:0]  bar_idx;
  logic [23:0] bar_px;
  logic [7:0]  grad_b;
  logic [23:0] pattern_px;

  logic        de_c, hs_c, vs_c, fs_c;
  logic [23:0] pixel_c;
  logic [11:0] x_c, y_c;

  // The vertical counter only wraps on the horizontal wrap, so its carry
  // marks the very last clock of the frame.
  vtg_counter #(.WIDTH(COORD_W), .MODULUS(H_TOTAL)) u_h_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run),
    .inc   (run),
    .count (h_cnt),
    .carry (h_carry)
  );

  vtg_counter #(.WIDTH(COORD_W), .MODULUS(V_TOTAL)) u_v_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!run),
    .inc   (h_carry),
    .count (v_cnt),
    .carry (v_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Leaving RUN is only possible on the final clock of a frame.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (en) state_next = ST_RUN;
      ST_RUN:  if (v_carry && !en) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Pattern controls are captured when a frame is about to begin: on entry
  // to RUN and on every frame wrap, so they never change within a frame.
  always_comb begin
    run        = (state == ST_RUN);
    latch_load = (state == ST_IDLE && en) || (state == ST_RUN && v_carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_BARS;
      rgb_q <= '0;
    end else if (latch_load) begin
      pat_q <= pattern_sel;
      rgb_q <= solid_rgb;
    end
  end

  // Bar index by threshold compare avoids a divider; anything right of the
  // last full bar stays black.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= COORD_W'(i * BAR_W)) bar_idx = 3'(i);
    end
    bar_px = (h_cnt < BARS_END) ? bar_colour(bar_idx) : 24'h000000;
    grad_b = h_cnt[7:0] + v_cnt[7:0];
    case (pat_q)
      PAT_BARS:     pattern_px = bar_px;
      PAT_GRADIENT: pattern_px = {h_cnt[7:0], v_cnt[7:0], grad_b};
      PAT_CHECKER:  pattern_px = (h_cnt[3] ^ v_cnt[3]) ? 24'hFFFFFF : 24'h000000;
      default:      pattern_px = rgb_q;
    endcase
  end

  always_comb begin
    de_c    = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_c    = run && (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_c    = run && (v_cnt >= VS_START) && (v_cnt < VS_END);
    fs_c    = de_c && (h_cnt == '0) && (v_cnt == '0);
    pixel_c = de_c ? pattern_px : 24'h000000;
    x_c     = de_c ? h_cnt : '0;
    y_c     = de_c ? v_cnt : '0;
  end

  // Single output register stage: one clock of latency from the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out      <= 1'b0;
      h_sync_out  <= 1'b0;
      v_sync_out  <= 1'b0;
      pixel_out   <= '0;
      x_out       <= '0;
      y_out       <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      de_out      <= de_c;
      h_sync_out  <= hs_c;
      v_sync_out  <= vs_c;
      pixel_out   <= pixel_c;
      x_out       <= x_c;
      y_out       <= y_c;
      frame_start <= fs_c;
      busy        <= run;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen -- directed self-checking bench for video_timing_gen.
//
// Purpose:
//   Drives a small 8x4 raster (14 clocks per line, 7 lines, 98 clocks per
//   frame) through bars, a mid-frame pattern change, a graceful stop, a
//   gradient run interrupted by reset, plus a 32x32 instance for the
//   checkerboard pattern. Expected values come from hand-derived formulas.
//
// Ports: none (top-level bench).
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        de_out, h_sync_out, v_sync_out, frame_start, busy;
  logic [23:0] pixel_out;
  logic [11:0] x_out, y_out;

  logic        enCb;
  logic [1:0]  patternCb;
  logic        deCb, hSyncCb, vSyncCb, frameStartCb, busyCb;
  logic [23:0] pixelCb;
  logic [11:0] xCb, yCb;

  int checkCount = 0;
  int errorCount = 0;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .de_out      (de_out),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .pixel_out   (pixel_out),
    .x_out       (x_out),
    .y_out       (y_out),
    .frame_start (frame_start),
    .busy        (busy)
  );

  video_timing_gen #(
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(32), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dutCb (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (enCb),
    .pattern_sel (patternCb),
    .solid_rgb   (24'h000000),
    .de_out      (deCb),
    .h_sync_out  (hSyncCb),
    .v_sync_out  (vSyncCb),
    .pixel_out   (pixelCb),
    .x_out       (xCb),
    .y_out       (yCb),
    .frame_start (frameStartCb),
    .busy        (busyCb)
  );

  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic enV, input logic [1:0] pat, input logic [23:0] rgb);
    en          = enV;
    pattern_sel = pat;
    solid_rgb   = rgb;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [23:0] barRef(input int i);
    case (i)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [63:0] allOut();
    return {11'd0, de_out, h_sync_out, v_sync_out, frame_start, busy, pixel_out, x_out, y_out};
  endfunction

  // Main sequence: every sample n corresponds to frame clock n of the
  // counters, observed one clock later on the registered outputs.
  initial begin
    int h, v, f;
    int deTotal, hsTotal, vsTotal;
    logic expDe, expHs, expVs, expFs;
    logic [23:0] expPix;

    rst_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 24'h0);
    enCb      = 1'b0;
    patternCb = 2'd2;
    #1 rst_n = 1'b0;
    #1 checkOutput("reset outputs", allOut(), 64'd0);
    tick;
    tick;
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput($sformatf("idle without en %0d", i), allOut(), 64'd0);
    end

    // Bars frame, solid frame requested mid-frame, en dropped in frame 2.
    applyStimulus(1'b1, 2'd0, 24'h0);
    tick;
    checkOutput("entry cycle outputs", allOut(), 64'd0);
    deTotal = 0; hsTotal = 0; vsTotal = 0;
    for (int n = 0; n < 196; n++) begin
      tick;
      h = n % 14;
      v = (n / 14) % 7;
      f = n / 98;
      expDe  = (h < 8) && (v < 4);
      expHs  = (h >= 10) && (h < 12);
      expVs  = (v == 5);
      expFs  = (h == 0) && (v == 0);
      expPix = expDe ? ((f == 0) ? barRef(h) : 24'h123456) : 24'h000000;
      checkOutput($sformatf("flags n=%0d", n),
                  {59'd0, de_out, h_sync_out, v_sync_out, frame_start, busy},
                  {59'd0, expDe, expHs, expVs, expFs, 1'b1});
      checkOutput($sformatf("pixel n=%0d", n), {40'd0, pixel_out}, {40'd0, expPix});
      checkOutput($sformatf("coord n=%0d", n), {40'd0, x_out, y_out},
                  expDe ? {40'd0, 12'(h), 12'(v)} : 64'd0);
      deTotal += int'(de_out);
      hsTotal += int'(h_sync_out);
      vsTotal += int'(v_sync_out);
      if (n == 40)  applyStimulus(1'b1, 2'd3, 24'h123456);
      if (n == 128) applyStimulus(1'b0, 2'd3, 24'h123456);
    end
    checkOutput("de count 2 frames", 64'(deTotal), 64'd64);
    checkOutput("hsync count 2 frames", 64'(hsTotal), 64'd28);
    checkOutput("vsync count 2 frames", 64'(vsTotal), 64'd28);
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput($sformatf("stopped %0d", i), allOut(), 64'd0);
    end

    // Gradient run, reset asserted at frame clock 50.
    applyStimulus(1'b1, 2'd1, 24'h0);
    tick;
    for (int n = 0; n <= 50; n++) begin
      tick;
      h = n % 14;
      v = (n / 14) % 7;
      expDe  = (h < 8) && (v < 4);
      expPix = expDe ? {8'(h), 8'(v), 8'(h + v)} : 24'h000000;
      checkOutput($sformatf("gradient n=%0d", n), {40'd0, pixel_out}, {40'd0, expPix});
      checkOutput($sformatf("gradient busy n=%0d", n), {63'd0, busy}, 64'd1);
    end
    rst_n = 1'b0;
    #1 checkOutput("async reset mid-frame", allOut(), 64'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    checkOutput("post-reset entry", allOut(), 64'd0);
    tick;
    checkOutput("post-reset frame_start",
                {59'd0, de_out, h_sync_out, v_sync_out, frame_start, busy},
                {59'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    checkOutput("post-reset coord", {40'd0, x_out, y_out}, 64'd0);
    tick;
    checkOutput("post-reset pixel 1", {40'd0, pixel_out}, 64'h010001);
    applyStimulus(1'b0, 2'd1, 24'h0);

    // Checkerboard on the 32x32 instance (38 clocks per line).
    enCb = 1'b1;
    tick;
    for (int n = 0; n <= 312; n++) begin
      tick;
      if (n == 0)   checkOutput("checker (0,0)",  {40'd0, pixelCb}, 64'h000000);
      if (n == 8)   checkOutput("checker (8,0)",  {40'd0, pixelCb}, 64'hFFFFFF);
      if (n == 16)  checkOutput("checker (16,0)", {40'd0, pixelCb}, 64'h000000);
      if (n == 304) checkOutput("checker (0,8)",  {40'd0, pixelCb}, 64'hFFFFFF);
      if (n == 312) checkOutput("checker (8,8)",  {40'd0, pixelCb}, 64'h000000);
    end
    enCb = 1'b0;

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
